mul_unit: RTL
=============

Name: mul_unit

Overview:
Iterative shift-add 32x32 multiplier for the multicycle core. It implements ARM MUL and MLA, producing the low 32 bits of the result.
- Sits downstream of the register file: rm/rs/rn are taken from the read ports, with rn fetched by the controller in an earlier cycle.
- Feeds the result back to the register-file write port together with its destination register index.
- The controller stalls on busy and consumes done/we_out.

Parameters:
WIDTH, 32, operand and result width in bits; the counter width is $clog2(WIDTH).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous reset, active-low; sampled only on the rising edge of clk
start  input  1  launch request; sampled only when the FSM is in IDLE or DONE
op_mla  input  1  1 = MLA (rm*rs+rn), 0 = MUL (rm*rs)
rm  input  WIDTH  multiplicand
rs  input  WIDTH  multiplier
rn  input  WIDTH  accumulate operand, used only when op_mla=1
wa_in  input  4  destination register index, captured at start
busy  output  1  high while in CALC
done  output  1  one-cycle pulse: result is valid
we_out  output  1  write-enable to the register file; equal to done
wa_out  output  4  captured destination index, held until the next accepted start
result  output  WIDTH  accumulator; held until the next accepted start
flag_n  output  1  result[WIDTH-1], valid while done=1
flag_z  output  1  (result==0), valid while done=1

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - busy, done, we_out, flag_n, flag_z = 0; result = 0; wa_out = 0.
  - Internal mcand, mplier and cnt = 0.
  - Reset mid-CALC aborts the operation; no done is produced for it.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 loads: acc <= op_mla ? rn : 0; mcand <= rm; mplier <= rs; wa_out <= wa_in; cnt <= 0.
  - The next state is CALC.
  - start=0 keeps the FSM in IDLE.
- CALC, at each edge:
  - if mplier[0], acc <= acc + mcand, modulo 2^WIDTH, with the carry discarded;
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - When cnt == WIDTH-1 at the edge, the next state is DONE.
  - start is ignored in CALC, and operand changes after launch have no effect.
- DONE:
  - done = we_out = 1 for exactly this one cycle; busy = 0.
  - start=1 is accepted exactly as in IDLE (back-to-back issue) and the next state is CALC.
  - Otherwise the next state is IDLE.
- Latency: start sampled at edge E0; the FSM is in CALC for WIDTH cycles (edges E1..E32 with the defaults), and done is high in the cycle following E32. This is 33 cycles from launch to done.
- Arithmetic:
  - Unsigned accumulation; the low WIDTH bits are identical for signed operands.
  - No overflow flag.
  - No C or V flag output; the controller preserves C and V for MUL/MLA.
- Flags are combinational from result and are gated to 0 while done=0.
- result and wa_out stay stable through IDLE until the next accepted start.

Optional Feature:
Macro MUL_EARLY_TERM_EN.
- Defined:
  - In CALC, if the post-shift mplier is 0 (all remaining multiplier bits zero), the next state is DONE regardless of cnt.
  - If rs==0 at start, the FSM still spends one CALC cycle and done appears 2 cycles after the launch edge.
  - Latency = 1 + (index of the highest set bit of rs) + 1 cycles; maximum 33.
  - Results are identical to the undefined case.
- Undefined: fixed WIDTH-cycle CALC for every operand set.

Test Plan:
1. Reset sequence: reset_n=0 for 2 cycles, then 1 -> busy=0, done=0, we_out=0, result=0, wa_out=0; no done for 5 idle cycles.
2. MUL, rm=7, rs=6, wa_in=3 -> busy for 32 cycles, then done=we_out=1 for one cycle with result=42, wa_out=3, flag_n=0, flag_z=0; result holds 42 afterwards.
3. MLA wrap, rm=0xFFFFFFFF, rs=2, rn=5 -> result=0x00000003, flag_n=0, flag_z=0. Then MUL rm=0x80000000, rs=1 -> result=0x80000000, flag_n=1.
4. Zero result, MUL rm=0x1234, rs=0 -> result=0, flag_z=1; done at cycle 33 (macro undefined) or cycle 2 (macro defined). A second run with rs=0x10 gives done at cycle 33 (undefined) or cycle 6 (defined).
5. Back-to-back and start ignored: start in DONE with rm=3, rs=3 -> the second done follows, result=9. Start pulses and operand changes during CALC do not alter the result or the timing.
6. Reset mid-op: reset_n=0 at CALC cycle 10 -> IDLE, all outputs 0; done is never asserted for the aborted operation. The next start then completes normally.

Source files
------------

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for MUL/MLA, producing the low WIDTH bits of rm*rs (+rn).
// Optional MUL_EARLY_TERM_EN ends CALC as soon as the remaining multiplier bits are all zero.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_mla,
  input  logic [WIDTH-1:0] rm,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rn,
  input  logic [3:0]       wa_in,
  output logic             busy,
  output logic             done,
  output logic             we_out,
  output logic [3:0]       wa_out,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CW-1:0]    cnt_r;
  logic [3:0]       wa_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] mplier_nxt_s;
  logic             calc_last_s;

  // Decide whether the current CALC edge is the final one.
  always_comb begin
    mplier_nxt_s = mplier_r >> 1;
`ifdef MUL_EARLY_TERM_EN
    if ((cnt_r == CNT_LAST) || (mplier_nxt_s == {WIDTH{1'b0}})) begin
      calc_last_s = 1'b1;
    end else begin
      calc_last_s = 1'b0;
    end
`else
    if (cnt_r == CNT_LAST) begin
      calc_last_s = 1'b1;
    end else begin
      calc_last_s = 1'b0;
    end
`endif
  end

  // Control FSM plus datapath registers; DONE accepts a new start like IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      wa_r     <= 4'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            acc_r    <= op_mla ? rn : {WIDTH{1'b0}};
            mcand_r  <= rm;
            mplier_r <= rs;
            wa_r     <= wa_in;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= ST_CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_nxt_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (calc_last_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_CALC;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign we_out = done_r;
  assign wa_out = wa_r;
  assign result = acc_r;
  // Flags are only meaningful in the done cycle.
  assign flag_n = done_r & acc_r[WIDTH-1];
  assign flag_z = done_r & ~(|acc_r);

endmodule
